// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for the asynchronous FIFO (read clock domain only).
//   It issues FIFO reads, absorbs the one-cycle read-data latency in a
//   3-entry skid buffer, and presents the words as a valid/ready stream.
//   out_ready never reaches fifo_ren combinationally: read issue depends only
//   on registered occupancy, so full throughput needs 3 entries (1 being
//   popped, 1 landing, 1 requested).
//
// Ports
//   clk_r       read-domain clock
//   rst_n       asynchronous active-low reset
//   en          allow new FIFO reads (buffered / in-flight data still drains)
//   flush       synchronous drop of buffered and in-flight data
//   fifo_empty  FIFO empty flag
//   fifo_ren    FIFO read enable
//   fifo_rdata  FIFO read data, valid the cycle after a granted read
//   out_valid   stream valid
//   out_ready   stream ready
//   out_data    stream data (head of buffer)
//   beat_cnt    completed out handshakes, modulo 2^CNT_W
module fifo_rd_stream #(
  parameter int WIDTH_FIFO = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_r,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [WIDTH_FIFO-1:0] fifo_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_FIFO-1:0] out_data,
  output logic [CNT_W-1:0]      beat_cnt
);

  logic [WIDTH_FIFO-1:0] buf_mem [3];
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [2:0]            reserved;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already owned: buffered words plus the word returning this cycle.
  // A pop in this cycle is deliberately ignored to keep out_ready off the
  // fifo_ren path.
  assign reserved  = {1'b0, occ} + {2'b00, inflight};
  assign fifo_ren  = en & ~fifo_empty & ~flush & (reserved < 3'd3);

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_mem[rd_ptr];

  assign capture   = inflight & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      // fifo_ren is forced low during flush, so this also drops the read.
      inflight <= fifo_ren;
      // A handshake in the flush cycle still completes and is counted.
      if (pop) beat_cnt <= beat_cnt + CNT_W'(1);
      if (flush) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
        occ    <= 2'd0;
      end else begin
        if (capture) begin
          buf_mem[wr_ptr] <= fifo_rdata;
          wr_ptr          <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_r) disable iff (!rst_n)
    reserved <= 3'd3);
  a_no_empty_read: assert property (@(posedge clk_r) disable iff (!rst_n)
    !(fifo_ren && fifo_empty));
`endif

endmodule
